// File: rtl/cgra_mesh_router.sv
// Streaming X-first / Y-fallback edge router for a GRID_W x GRID_H CGRA mesh with hop-by-hop
// occupancy commit and full rollback. Optional per-result counters: define CGRA_ROUTE_STATS_EN.
module cgra_mesh_router #(
   parameter int GRID_W     = 4,
   parameter int GRID_H     = 4,
   parameter int MAX_BYPASS = 2,
   parameter int ID_W       = $clog2(GRID_W*GRID_H),
   parameter int HOP_W      = $clog2(GRID_W+GRID_H-1)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  clear,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [ID_W-1:0]                       in_src,
   input  logic [ID_W-1:0]                       in_dst,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  out_ok,
   output logic [HOP_W-1:0]                      out_hops,
   input  logic [ID_W-1:0]                       occ_addr,
   output logic [4+$clog2(MAX_BYPASS+1)-1:0]     occ_data,
   output logic [15:0]                           stat_ok_cnt,
   output logic [15:0]                           stat_fail_cnt
);

   localparam int N     = GRID_W*GRID_H;
   localparam int BW    = $clog2(MAX_BYPASS+1);
   localparam int DEPTH = GRID_W+GRID_H-2;
   localparam int SP_W  = $clog2(DEPTH+1);

   // Link bit positions inside a PE's occupancy nibble; the bit belongs to the PE being exited.
   localparam logic [1:0] D_BOT = 2'd0, D_TOP = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_HOP, S_ROLLBACK, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   cur_q, cur_d, dst_q, dst_d;
   logic [HOP_W-1:0]  hops_q, hops_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              ok_q, ok_d;
   logic              out_valid_q, out_valid_d;

   logic [3:0]        link_q [N];
   logic [3:0]        link_d [N];
   logic [BW-1:0]     byp_q  [N];
   logic [BW-1:0]     byp_d  [N];

   logic [ID_W-1:0]   stk_pe_q  [DEPTH];
   logic [ID_W-1:0]   stk_pe_d  [DEPTH];
   logic [1:0]        stk_dir_q [DEPTH];
   logic [1:0]        stk_dir_d [DEPTH];
   logic              stk_byp_q [DEPTH];
   logic              stk_byp_d [DEPTH];

   int unsigned       cx, cy, dx, dy;
   logic              byp_full, x_go, y_go;
   logic [1:0]        x_dir, y_dir, mv_dir;
   logic [ID_W-1:0]   x_nxt, y_nxt, mv_nxt;
   logic [ID_W-1:0]   top_pe;
   logic [1:0]        top_dir;
   logic              top_byp;

   function automatic int unsigned col(input logic [ID_W-1:0] idx);
      return 32'(idx) % 32'(GRID_W);
   endfunction

   function automatic int unsigned row(input logic [ID_W-1:0] idx);
      return 32'(idx) / 32'(GRID_W);
   endfunction

   // Candidate moves from the current PE; a PE already routing MAX_BYPASS paths blocks both.
   always_comb begin
      cx       = col(cur_q);
      cy       = row(cur_q);
      dx       = col(dst_q);
      dy       = row(dst_q);
      byp_full = (hops_q != '0) && (byp_q[cur_q] == BW'(MAX_BYPASS));
      x_dir    = (dx > cx) ? D_RIGHT : D_LEFT;
      y_dir    = (dy > cy) ? D_BOT : D_TOP;
      x_nxt    = (dx > cx) ? cur_q + ID_W'(1) : cur_q - ID_W'(1);
      y_nxt    = (dy > cy) ? cur_q + ID_W'(GRID_W) : cur_q - ID_W'(GRID_W);
      x_go     = (cx != dx) && !byp_full && !link_q[cur_q][x_dir];
      y_go     = (cy != dy) && !byp_full && !link_q[cur_q][y_dir];
      mv_dir   = x_go ? x_dir : y_dir;
      mv_nxt   = x_go ? x_nxt : y_nxt;
      top_pe   = stk_pe_q[sp_q - SP_W'(1)];
      top_dir  = stk_dir_q[sp_q - SP_W'(1)];
      top_byp  = stk_byp_q[sp_q - SP_W'(1)];
   end

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
   // out_valid and its payload hold steady until that edge, and in_ready never waits on in_valid.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      dst_d       = dst_q;
      hops_d      = hops_q;
      sp_d        = sp_q;
      ok_d        = ok_q;
      out_valid_d = out_valid_q;
      link_d      = link_q;
      byp_d       = byp_q;
      stk_pe_d    = stk_pe_q;
      stk_dir_d   = stk_dir_q;
      stk_byp_d   = stk_byp_q;
      in_ready    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clear) begin
               for (int i = 0; i < N; i++) begin
                  link_d[i] = '0;
                  byp_d[i]  = '0;
               end
            end else begin
               in_ready = !reset;
               if (in_valid && !reset) begin
                  cur_d  = in_src;
                  dst_d  = in_dst;
                  hops_d = '0;
                  sp_d   = '0;
                  ok_d   = 1'b0;
                  if ((32'(in_src) >= 32'(N)) || (32'(in_dst) >= 32'(N))) state_d = S_RESP;
                  else state_d = S_HOP;
               end
            end
         end
         S_HOP: begin
            if (cur_q == dst_q) begin
               ok_d    = 1'b1;
               state_d = S_RESP;
            end else if (x_go || y_go) begin
               link_d[cur_q][mv_dir] = 1'b1;
               if (hops_q != '0) byp_d[cur_q] = byp_q[cur_q] + BW'(1);
               stk_pe_d[sp_q]  = cur_q;
               stk_dir_d[sp_q] = mv_dir;
               stk_byp_d[sp_q] = (hops_q != '0);
               sp_d            = sp_q + SP_W'(1);
               cur_d           = mv_nxt;
               hops_d          = hops_q + HOP_W'(1);
            end else if (sp_q != '0) begin
               state_d = S_ROLLBACK;
            end else begin
               hops_d  = '0;
               state_d = S_RESP;
            end
         end
         S_ROLLBACK: begin
            link_d[top_pe][top_dir] = 1'b0;
            if (top_byp) byp_d[top_pe] = byp_q[top_pe] - BW'(1);
            sp_d = sp_q - SP_W'(1);
            if (sp_q == SP_W'(1)) begin
               hops_d  = '0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            out_valid_d = 1'b1;
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         dst_q       <= '0;
         hops_q      <= '0;
         sp_q        <= '0;
         ok_q        <= 1'b0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            link_q[i] <= '0;
            byp_q[i]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         dst_q       <= dst_d;
         hops_q      <= hops_d;
         sp_q        <= sp_d;
         ok_q        <= ok_d;
         out_valid_q <= out_valid_d;
         link_q      <= link_d;
         byp_q       <= byp_d;
      end
   end

   // Stack contents are only read below sp, so they need no reset.
   always_ff @(posedge clk) begin
      stk_pe_q  <= stk_pe_d;
      stk_dir_q <= stk_dir_d;
      stk_byp_q <= stk_byp_d;
   end

   assign out_valid = out_valid_q;
   assign out_ok    = out_valid_q & ok_q;
   assign out_hops  = out_valid_q ? hops_q : '0;

   always_comb begin
      occ_data = '0;
      if (32'(occ_addr) < 32'(N)) occ_data = {byp_q[occ_addr], link_q[occ_addr]};
   end

`ifdef CGRA_ROUTE_STATS_EN
   logic [15:0] ok_cnt_q, ok_cnt_d, fail_cnt_q, fail_cnt_d;

   always_comb begin
      ok_cnt_d   = ok_cnt_q;
      fail_cnt_d = fail_cnt_q;
      if ((state_q == S_IDLE) && clear) begin
         ok_cnt_d   = '0;
         fail_cnt_d = '0;
      end else if ((state_q == S_RESP) && out_valid_q && out_ready) begin
         if (ok_q) begin
            if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
         end else begin
            if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ok_cnt_q   <= '0;
         fail_cnt_q <= '0;
      end else begin
         ok_cnt_q   <= ok_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign stat_ok_cnt   = ok_cnt_q;
   assign stat_fail_cnt = fail_cnt_q;
`else
   assign stat_ok_cnt   = '0;
   assign stat_fail_cnt = '0;
`endif

endmodule

// File: tb/tb_cgra_mesh_router.sv
// Bench for cgra_mesh_router: two 4x4 instances (MAX_BYPASS 2 and 1) checked against a
// path-list reference model of the routing rules, directed scenarios plus random edges.
module tb_cgra_mesh_router;
   localparam int GW  = 4;
   localparam int NPE = 16;

   logic clk = 1'b0;
   logic reset;
   always #20 clk = ~clk;

   logic        in_valid [2];
   logic        clear    [2];
   logic        out_ready[2];
   logic        in_ready [2];
   logic        out_valid[2];
   logic        out_ok   [2];
   logic [3:0]  in_src   [2];
   logic [3:0]  in_dst   [2];
   logic [3:0]  occ_addr [2];
   logic [2:0]  out_hops [2];
   logic [15:0] st_ok    [2];
   logic [15:0] st_fail  [2];
   logic [5:0]  occ0;
   logic [4:0]  occ1;

   cgra_mesh_router #(.GRID_W(4), .GRID_H(4), .MAX_BYPASS(2)) dut_b2 (
      .clk(clk), .reset(reset), .clear(clear[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_src(in_src[0]), .in_dst(in_dst[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ok(out_ok[0]), .out_hops(out_hops[0]),
      .occ_addr(occ_addr[0]), .occ_data(occ0),
      .stat_ok_cnt(st_ok[0]), .stat_fail_cnt(st_fail[0])
   );

   cgra_mesh_router #(.GRID_W(4), .GRID_H(4), .MAX_BYPASS(1)) dut_b1 (
      .clk(clk), .reset(reset), .clear(clear[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_src(in_src[1]), .in_dst(in_dst[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ok(out_ok[1]), .out_hops(out_hops[1]),
      .occ_addr(occ_addr[1]), .occ_data(occ1),
      .stat_ok_cnt(st_ok[1]), .stat_fail_cnt(st_fail[1])
   );

   int vec  = 0;
   int miss = 0;

   // Reference model: per-unit link bits {right,left,top,bot}, bypass counts, result counters.
   bit [3:0]   m_link [2][NPE];
   int         m_byp  [2][NPE];
   int         m_okc  [2];
   int         m_failc[2];
   logic [3:0] exp_q[$];

   function automatic int mb(input int u);
      return (u == 0) ? 2 : 1;
   endfunction

   task automatic model_wipe(input int u);
      for (int p = 0; p < NPE; p++) begin
         m_link[u][p] = '0;
         m_byp[u][p]  = 0;
      end
      m_okc[u]   = 0;
      m_failc[u] = 0;
   endtask

   // Walks the edge on the model mesh; returns result and the expected accept-to-valid latency.
   task automatic model_route(input int u, input int s, input int d,
                              output bit ok, output int hops, output int lat);
      int pq[$];
      int dq[$];
      bit fq[$];
      int cur;
      cur  = s;
      hops = 0;
      ok   = 1'b0;
      lat  = 0;
      for (int step = 0; step < 64; step++) begin
         int cx, cy, dx, dy, mv, nxt;
         bit full;
         cx = cur % GW; cy = cur / GW; dx = d % GW; dy = d / GW;
         if (cur == d) begin
            ok  = 1'b1;
            lat = hops + 2;
            break;
         end
         full = (hops != 0) && (m_byp[u][cur] == mb(u));
         mv   = -1;
         nxt  = cur;
         if (!full && cx != dx && !m_link[u][cur][(dx > cx) ? 3 : 2]) begin
            mv  = (dx > cx) ? 3 : 2;
            nxt = cur + ((dx > cx) ? 1 : -1);
         end else if (!full && cy != dy && !m_link[u][cur][(dy > cy) ? 0 : 1]) begin
            mv  = (dy > cy) ? 0 : 1;
            nxt = cur + ((dy > cy) ? GW : -GW);
         end
         if (mv < 0) begin
            lat  = 2 * pq.size() + 2;
            hops = 0;
            while (pq.size() > 0) begin
               int p, dr;
               p  = pq.pop_back();
               dr = dq.pop_back();
               m_link[u][p][dr] = 1'b0;
               if (fq.pop_back()) m_byp[u][p]--;
            end
            break;
         end
         m_link[u][cur][mv] = 1'b1;
         fq.push_back(hops != 0);
         if (hops != 0) m_byp[u][cur]++;
         pq.push_back(cur);
         dq.push_back(mv);
         cur = nxt;
         hops++;
      end
   endtask

   task automatic check_occ(input int u, input string tag);
      @(negedge clk);
      for (int pe = 0; pe < NPE; pe++) begin
         logic [5:0] e, a;
         occ_addr[u] = 4'(pe);
         #1;
         e = 6'(m_byp[u][pe] * 16 + int'(m_link[u][pe]));
         a = (u == 0) ? occ0 : {1'b0, occ1};
         vec++;
         if (a !== e) begin
            miss++;
            $display("FAIL %s occ u%0d pe%0d got %b want %b", tag, u, pe, a, e);
         end
      end
   endtask

   task automatic check_stats(input int u, input string tag);
      int eo, ef;
`ifdef CGRA_ROUTE_STATS_EN
      eo = m_okc[u];
      ef = m_failc[u];
`else
      eo = 0;
      ef = 0;
`endif
      vec++;
      if (st_ok[u] !== 16'(eo)) begin
         miss++;
         $display("FAIL %s stat_ok u%0d got %0d want %0d", tag, u, st_ok[u], eo);
      end
      vec++;
      if (st_fail[u] !== 16'(ef)) begin
         miss++;
         $display("FAIL %s stat_fail u%0d got %0d want %0d", tag, u, st_fail[u], ef);
      end
   endtask

   task automatic do_clear(input int u);
      @(negedge clk);
      clear[u]    = 1'b1;
      in_valid[u] = 1'b1;
      in_src[u]   = 4'd0;
      in_dst[u]   = 4'd15;
      #1;
      vec++;
      if (in_ready[u] !== 1'b0) begin
         miss++;
         $display("FAIL clear_in_ready u%0d got %b want 0", u, in_ready[u]);
      end
      @(posedge clk);
      #1;
      clear[u]    = 1'b0;
      in_valid[u] = 1'b0;
      model_wipe(u);
   endtask

   task automatic send_edge(input int u, input int s, input int d, input int hold, input string tag);
      bit         eok;
      int         ehops, elat, got;
      logic [3:0] e;
      model_route(u, s, d, eok, ehops, elat);
      exp_q.push_back({eok, 3'(ehops)});
      @(negedge clk);
      in_valid[u] = 1'b1;
      in_src[u]   = 4'(s);
      in_dst[u]   = 4'(d);
      #1;
      vec++;
      if (in_ready[u] !== 1'b1) begin
         miss++;
         $display("FAIL %s in_ready u%0d got %b want 1", tag, u, in_ready[u]);
      end
      @(posedge clk);
      #1;
      in_valid[u] = 1'b0;
      got = 0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (out_valid[u] === 1'b1) begin
            got = c;
            break;
         end
      end
      e = exp_q.pop_front();
      vec++;
      if (got != elat) begin
         miss++;
         $display("FAIL %s latency u%0d %0d->%0d got %0d want %0d (0 = no response)", tag, u, s, d, got, elat);
      end
      vec++;
      if ({out_ok[u], out_hops[u]} !== e) begin
         miss++;
         $display("FAIL %s result u%0d %0d->%0d got ok=%b hops=%0d want ok=%b hops=%0d",
                  tag, u, s, d, out_ok[u], out_hops[u], e[3], e[2:0]);
      end
      for (int c = 0; c < hold; c++) begin
         in_valid[u] = 1'b1;
         in_src[u]   = 4'($urandom_range(0, 15));
         in_dst[u]   = 4'($urandom_range(0, 15));
         @(posedge clk);
         #1;
         vec++;
         if (out_valid[u] !== 1'b1 || {out_ok[u], out_hops[u]} !== e || in_ready[u] !== 1'b0) begin
            miss++;
            $display("FAIL %s hold u%0d cyc%0d got v=%b ok=%b hops=%0d rdy=%b want v=1 ok=%b hops=%0d rdy=0",
                     tag, u, c, out_valid[u], out_ok[u], out_hops[u], in_ready[u], e[3], e[2:0]);
         end
      end
      out_ready[u] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[u] = 1'b0;
      in_valid[u]  = 1'b0;
      vec++;
      if (out_valid[u] !== 1'b0) begin
         miss++;
         $display("FAIL %s post_handshake u%0d out_valid got %b want 0", tag, u, out_valid[u]);
      end
      if (eok) m_okc[u]++;
      else m_failc[u]++;
      check_stats(u, tag);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         vec++;
         if (in_ready[u] !== 1'b0 || out_valid[u] !== 1'b0 || out_ok[u] !== 1'b0 || out_hops[u] !== 3'd0) begin
            miss++;
            $display("FAIL reset_outputs u%0d got rdy=%b v=%b ok=%b hops=%0d want all 0",
                     u, in_ready[u], out_valid[u], out_ok[u], out_hops[u]);
         end
         model_wipe(u);
         check_stats(u, "reset");
         check_occ(u, "reset");
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      for (int u = 0; u < 2; u++) begin
         vec++;
         if (in_ready[u] !== 1'b1) begin
            miss++;
            $display("FAIL idle_in_ready u%0d got %b want 1", u, in_ready[u]);
         end
      end
   endtask

   task automatic test_x_then_y();
      int         pes[7]  = '{0, 1, 2, 3, 7, 11, 15};
      logic [5:0] want[7] = '{6'h08, 6'h18, 6'h18, 6'h11, 6'h11, 6'h11, 6'h00};
      send_edge(0, 0, 15, 0, "x_then_y");
      check_occ(0, "x_then_y");
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         occ_addr[0] = 4'(pes[i]);
         #1;
         vec++;
         if (occ0 !== want[i]) begin
            miss++;
            $display("FAIL x_then_y_pe pe%0d got %b want %b", pes[i], occ0, want[i]);
         end
      end
      send_edge(0, 0, 3, 0, "blocked_at_src");
      check_occ(0, "blocked_at_src");
   endtask

   task automatic test_rollback();
      do_clear(0);
      send_edge(0, 1, 3, 0, "rb_setup_a");
      send_edge(0, 4, 7, 0, "rb_setup_b");
      send_edge(0, 0, 7, 0, "rollback");
      check_occ(0, "rollback");
   endtask

   task automatic test_bypass_limit();
      do_clear(1);
      send_edge(1, 4, 2, 0, "byp1_a");
      send_edge(1, 1, 9, 0, "byp1_b");
      check_occ(1, "byp1");
      @(negedge clk);
      occ_addr[1] = 4'd1;
      #1;
      vec++;
      if (occ1[0] !== 1'b0) begin
         miss++;
         $display("FAIL byp1_pe1_bot got %b want 0", occ1[0]);
      end
      do_clear(0);
      send_edge(0, 4, 2, 0, "byp2_a");
      send_edge(0, 1, 9, 0, "byp2_b");
      check_occ(0, "byp2");
   endtask

   task automatic test_backpressure();
      do_clear(0);
      send_edge(0, 5, 10, 5, "hold");
      check_occ(0, "hold");
      send_edge(0, 10, 5, 0, "after_hold");
   endtask

   task automatic test_reset_rollback();
      do_clear(0);
      send_edge(0, 1, 3, 0, "rr_setup_a");
      send_edge(0, 4, 7, 0, "rr_setup_b");
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_src[0]   = 4'd0;
      in_dst[0]   = 4'd7;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_wipe(0);
      model_wipe(1);
      for (int u = 0; u < 2; u++) begin
         vec++;
         if (out_valid[u] !== 1'b0) begin
            miss++;
            $display("FAIL reset_rb_valid u%0d got %b want 0", u, out_valid[u]);
         end
         check_occ(u, "reset_rb");
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         vec++;
         if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            miss++;
            $display("FAIL reset_rb_idle cyc%0d got v=%b rdy=%b want v=0 rdy=1", c, out_valid[0], in_ready[0]);
         end
      end
      check_stats(0, "reset_rb");
   endtask

   task automatic test_clear();
      send_edge(0, 0, 15, 0, "clr_setup");
      send_edge(0, 12, 3, 0, "clr_setup2");
      do_clear(0);
      check_occ(0, "clear");
      check_stats(0, "clear");
   endtask

   task automatic test_random();
      for (int i = 0; i < 90; i++) begin
         int u;
         u = int'($urandom_range(0, 1));
         if ($urandom_range(0, 11) == 0) do_clear(u);
         send_edge(u, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), "random");
         if (i % 9 == 8) check_occ(u, "random");
      end
      check_occ(0, "random_end");
      check_occ(1, "random_end");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      for (int u = 0; u < 2; u++) begin
         in_valid[u]  = 1'b0;
         clear[u]     = 1'b0;
         out_ready[u] = 1'b0;
         in_src[u]    = '0;
         in_dst[u]    = '0;
         occ_addr[u]  = '0;
      end
      test_reset();
      test_x_then_y();
      test_rollback();
      test_bypass_limit();
      test_backpressure();
      test_reset_rollback();
      test_clear();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
